sand_grid_sim: RTL

- Falling-sand physics engine that owns the 16x16 occupancy grid consumed by the LED matrix driver.
- Latches tilt from IMU accelerometer samples and periodically advances the grain simulation by one step.
- Publishes each completed frame as a registered 16x16 matrix plus a one-cycle frame_valid strobe.
- Sits between the IMU reader (upstream) and the WS2812 display stage (downstream).

---
 rtl/sand_pkg.sv | 44 ++++
 rtl/sand_grid_sim_if.sv | 25 ++
 rtl/sand_grid_sim_tilt_decode.sv | 36 +++
 rtl/sand_grid_sim.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
// Shared types and helpers for the falling-sand grid engine.
// Grid geometry, gravity/FSM enums and the sweep-order cell mapping.
package sand_pkg;

  localparam int GRID_N = 16;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    DOWN  = 3'd1,
    UP    = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } grav_dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP   = 2'd1,
    PUBLISH = 2'd2
  } sim_state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } cell_t;

  // Rows 0-3 full, everything else empty (row r lives in bits [16r +: 16]).
  localparam logic [GRID_N-1:0][GRID_N-1:0] INIT_GRID =
    {192'd0, 64'hFFFF_FFFF_FFFF_FFFF};

  // Sweep order visits the cells nearest the floor first, so a grain that
  // has just fallen is never visited again in the same step.
  function automatic cell_t cell_of(grav_dir_t dir, logic [3:0] i, logic [3:0] j);
    cell_t c;
    case (dir)
      DOWN:    begin c.row = 4'd15 - i; c.col = j;         end
      UP:      begin c.row = i;         c.col = j;         end
      RIGHT:   begin c.row = j;         c.col = 4'd15 - i; end
      LEFT:    begin c.row = j;         c.col = i;         end
      default: begin c.row = i;         c.col = j;         end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sand_grid_sim_if.sv
// IMU-side and display-side signals of the sand grid engine.
// accel_valid qualifies accel_x/accel_y and is always accepted (no ready);
// frame_valid is a one-cycle strobe in the same cycle matrix takes its new value.
interface sand_grid_sim_if;
  import sand_pkg::*;

  logic signed [15:0]               accel_x;
  logic signed [15:0]               accel_y;
  logic                             accel_valid;
  logic [GRID_N-1:0][GRID_N-1:0]    matrix;
  logic                             frame_valid;
  logic                             busy;
  sim_state_t                       state_dbg;

  modport master (
    output accel_x, accel_y, accel_valid,
    input  matrix, frame_valid, busy, state_dbg
  );

  modport slave (
    input  accel_x, accel_y, accel_valid,
    output matrix, frame_valid, busy, state_dbg
  );

endinterface

// File: rtl/sand_grid_sim_tilt_decode.sv
// Combinational tilt decoder: dominant accelerometer axis to gravity direction.
// Ties between |x| and |y| resolve horizontally; x = 0 on a tie means LEFT.
module tilt_decode
  import sand_pkg::*;
(
  input  logic signed [15:0] accel_x,
  input  logic signed [15:0] accel_y,
  input  logic signed [15:0] threshold,
  output grav_dir_t          dir
);

  // -32768 has no positive counterpart in 16 bits, so clamp it.
  function automatic logic [15:0] abs_sat(logic signed [15:0] v);
    if (v == 16'sh8000)   return 16'h7FFF;
    else if (v < 16'sd0)  return -v;
    else                  return v;
  endfunction

  logic [15:0] ax;
  logic [15:0] ay;
  logic        below_x;
  logic        below_y;

  always_comb begin
    ax      = abs_sat(accel_x);
    ay      = abs_sat(accel_y);
    below_x = $signed({1'b0, ax}) < $signed({threshold[15], threshold});
    below_y = $signed({1'b0, ay}) < $signed({threshold[15], threshold});
    dir     = NONE;
    if (!(below_x && below_y)) begin
      if (ay > ax) dir = (accel_y > 16'sd0) ? DOWN : UP;
      else         dir = (accel_x > 16'sd0) ? RIGHT : LEFT;
    end
  end

endmodule

// File: rtl/sand_grid_sim.sv
// Falling-sand engine: one 256-cell in-place sweep per step, then publish.
// Build with SAND_DIAG_EN defined to let blocked grains slide diagonally.
module sand_grid_sim
  import sand_pkg::*;
#(
  parameter int                 STEP_CYCLES = 2_000_000,
  parameter logic signed [15:0] TILT_THRESH = 16'sd2000
) (
  input logic            clock,
  input logic            reset,
  sand_grid_sim_if.slave io
);

  localparam int TW = $clog2(STEP_CYCLES);

  logic [TW-1:0]                 timer;
  logic                          tick;
  sim_state_t                    state;
  sim_state_t                    state_n;
  logic [7:0]                    idx;
  grav_dir_t                     dir_q;
  grav_dir_t                     dir_dec;
  logic                          bias;
  logic signed [15:0]            held_x;
  logic signed [15:0]            held_y;
  logic [GRID_N-1:0][GRID_N-1:0] grid;
  logic [GRID_N-1:0][GRID_N-1:0] matrix_q;
  logic                          frame_valid_q;

  cell_t                         src;
  logic                          occupied;
  logic signed [5:0]             g_r, g_c;
  logic signed [5:0]             t0_r, t0_c;
  logic                          t0_free;
  logic                          move_en;
  logic [3:0]                    dst_r, dst_c;
`ifdef SAND_DIAG_EN
  logic signed [5:0]             p_r, p_c;
  logic signed [5:0]             t1_r, t1_c, t2_r, t2_c;
  logic                          t1_free, t2_free;
`endif

  function automatic logic in_grid(logic signed [5:0] r, logic signed [5:0] c);
    return (r >= 6'sd0) && (r < 6'sd16) && (c >= 6'sd0) && (c < 6'sd16);
  endfunction

  // Free-running step timer; a tick is only honoured from IDLE.
  always_ff @(posedge clock) begin
    if (reset)     timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + 1'b1;
  end

  assign tick = (timer == TW'(STEP_CYCLES - 1));

  tilt_decode u_tilt_decode (
    .accel_x   (held_x),
    .accel_y   (held_y),
    .threshold (TILT_THRESH),
    .dir       (dir_dec)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = SWEEP;
      SWEEP:   if (idx == 8'hFF) state_n = PUBLISH;
      PUBLISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    io.busy      = (state != IDLE);
    io.state_dbg = state;
  end

  // Move decision for the cell visited this cycle; reads the in-place grid.
  always_comb begin
    src      = cell_of(dir_q, idx[7:4], idx[3:0]);
    occupied = grid[src.row][src.col];
    g_r      = 6'sd0;
    g_c      = 6'sd0;
    case (dir_q)
      DOWN:    g_r =  6'sd1;
      UP:      g_r = -6'sd1;
      RIGHT:   g_c =  6'sd1;
      LEFT:    g_c = -6'sd1;
      default: ;
    endcase
    t0_r    = $signed({2'b00, src.row}) + g_r;
    t0_c    = $signed({2'b00, src.col}) + g_c;
    t0_free = in_grid(t0_r, t0_c) && !grid[t0_r[3:0]][t0_c[3:0]];
`ifdef SAND_DIAG_EN
    // Perpendicular step follows the minor index: lower first unless bias.
    p_r     = (dir_q == LEFT || dir_q == RIGHT) ? (bias ? 6'sd1 : -6'sd1) : 6'sd0;
    p_c     = (dir_q == DOWN || dir_q == UP)    ? (bias ? 6'sd1 : -6'sd1) : 6'sd0;
    t1_r    = t0_r + p_r;
    t1_c    = t0_c + p_c;
    t2_r    = t0_r - p_r;
    t2_c    = t0_c - p_c;
    t1_free = in_grid(t1_r, t1_c) && !grid[t1_r[3:0]][t1_c[3:0]];
    t2_free = in_grid(t2_r, t2_c) && !grid[t2_r[3:0]][t2_c[3:0]];
`endif
    move_en = 1'b0;
    dst_r   = src.row;
    dst_c   = src.col;
    if (state == SWEEP && dir_q != NONE && occupied) begin
      if (t0_free) begin
        move_en = 1'b1;
        dst_r   = t0_r[3:0];
        dst_c   = t0_c[3:0];
      end
`ifdef SAND_DIAG_EN
      else if (t1_free) begin
        move_en = 1'b1;
        dst_r   = t1_r[3:0];
        dst_c   = t1_c[3:0];
      end else if (t2_free) begin
        move_en = 1'b1;
        dst_r   = t2_r[3:0];
        dst_c   = t2_c[3:0];
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grid          <= INIT_GRID;
      matrix_q      <= INIT_GRID;
      frame_valid_q <= 1'b0;
      bias          <= 1'b0;
      dir_q         <= NONE;
      idx           <= 8'd0;
      held_x        <= 16'sd0;
      held_y        <= 16'sd0;
    end else begin
      frame_valid_q <= 1'b0;
      if (io.accel_valid) begin
        held_x <= io.accel_x;
        held_y <= io.accel_y;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            dir_q <= dir_dec;
            idx   <= 8'd0;
          end
        end
        SWEEP: begin
          idx <= idx + 8'd1;
          if (move_en) begin
            grid[src.row][src.col] <= 1'b0;
            grid[dst_r][dst_c]     <= 1'b1;
          end
        end
        PUBLISH: begin
          matrix_q      <= grid;
          frame_valid_q <= 1'b1;
          bias          <= ~bias;
        end
        default: ;
      endcase
    end
  end

  assign io.matrix      = matrix_q;
  assign io.frame_valid = frame_valid_q;

endmodule
